qspi_cchan_req_exec: RTL

- Responder end of the command-channel (cchan) request interface.
- Accepts one request per valid/ready handshake (inst, addr, data size, burst length) and executes it as a single x1 SPI frame on the flash pins, SPI mode 0: instruction, optional 24-bit address, optional data bytes.
- Returns one response per request, carrying up to 4 bytes of read data.
- Sits between the cchan instruction generator and the flash pad logic, in parallel with the memory-mapped read path.

---
 rtl/qspi_cchan_req_exec_if.sv | 23 ++
 rtl/qspi_cchan_req_exec.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_cchan_req_exec_if.sv
// Command-channel request/response bundle between the cchan instruction
// generator (master) and the x1 SPI frame executor (slave).
interface qspi_cchan_req_exec_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_inst;
    logic [23:0] req_addr;
    logic [7:0]  req_data_size;
    logic [7:0]  req_data_burstlen;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_inst, req_addr, req_data_size, req_data_burstlen, wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_inst, req_addr, req_data_size, req_data_burstlen, wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/qspi_cchan_req_exec.sv
// Executes one cchan request as a single x1 SPI mode-0 frame (inst, optional address, data).
// Optional feature QSPI_CCHAN_BUSY_POLL_EN: erase/WRSR requests poll RDSR until WIP clears.
module qspi_cchan_req_exec #(
    parameter int         CLK_DIV    = 0,
    parameter int         CSH_CYCLES = 4,
    parameter logic [7:0] INST_SER   = 8'h20,
    parameter logic [7:0] INST_BER32 = 8'h52,
    parameter logic [7:0] INST_BER64 = 8'hD8,
    parameter logic [7:0] INST_CER   = 8'h60,
    parameter logic [7:0] INST_RDSR  = 8'h05,
    parameter logic [7:0] INST_RDFR  = 8'h48,
    parameter logic [7:0] INST_WRSR  = 8'h01
) (
    input  logic                         clock,
    input  logic                         rst_n,
    qspi_cchan_req_exec_if.slave         io_cchan,
    output logic                         io_qspi_sck,
    output logic                         io_qspi_cs_n,
    output logic                         io_qspi_dq0_o,
    output logic                         io_qspi_dq0_oe,
    input  logic                         io_qspi_dq1_i,
    output logic                         io_busy
);

    localparam int            HW       = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam logic [HW-1:0] HC_MAX   = HW'(CLK_DIV);
    localparam logic [7:0]    CSH_LAST = 8'(CSH_CYCLES - 1);

`ifdef QSPI_CCHAN_BUSY_POLL_EN
    typedef enum logic [2:0] {
        IDLE, CS_SETUP, INST, ADDR, DATA, CS_HOLD, CS_IDLE, POLL
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CS_SETUP, INST, ADDR, DATA, CS_HOLD, CS_IDLE
    } state_t;
`endif

    state_t        state, state_n;
    logic [HW-1:0] hc;
    logic          ph;
    logic [11:0]   bit_cnt;
    logic [11:0]   last_idx;
    logic [7:0]    inst_q;
    logic [23:0]   addr_q;
    logic [7:0]    blen_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rx_sr;
    logic          has_addr;
    logic          is_read;
    logic [7:0]    csh_cnt;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          half_end;
    logic          bit_end;
    logic          last_bit;
    logic          csh_done;
    logic          unused_data_size;

`ifdef QSPI_CCHAN_BUSY_POLL_EN
    logic poll_pend;
    logic in_poll;
    logic withhold;
    // The command frame itself and every poll with WIP still set stay silent.
    assign withhold = poll_pend & (~in_poll | rx_sr[0]);
`endif

    assign half_end = (hc == HC_MAX);
    assign bit_end  = half_end & ph;
    assign csh_done = (csh_cnt == CSH_LAST);
    assign last_idx = (state == INST) ? 12'd7 :
                      (state == ADDR) ? 12'd23 :
                      ({1'b0, blen_q, 3'b000} - 12'd1);
    assign last_bit = (bit_cnt == last_idx);

    assign io_cchan.req_ready  = (state == IDLE);
    assign io_cchan.resp_valid = resp_valid_q;
    assign io_cchan.resp_rdata = resp_rdata_q;
    assign io_busy             = (state != IDLE);
    assign io_qspi_sck         = ph;
    assign unused_data_size    = ^io_cchan.req_data_size;

    always_comb begin
        state_n        = state;
        io_qspi_cs_n   = 1'b0;
        io_qspi_dq0_o  = 1'b0;
        io_qspi_dq0_oe = 1'b0;
        case (state)
            IDLE: begin
                io_qspi_cs_n = 1'b1;
                if (io_cchan.req_valid) state_n = CS_SETUP;
            end
            CS_SETUP: begin
                if (half_end) state_n = INST;
            end
            INST: begin
                io_qspi_dq0_o  = inst_q[3'd7 - bit_cnt[2:0]];
                io_qspi_dq0_oe = 1'b1;
                if (bit_end && last_bit) begin
                    if (has_addr)          state_n = ADDR;
                    else if (blen_q != '0) state_n = DATA;
                    else                   state_n = CS_HOLD;
                end
            end
            ADDR: begin
                io_qspi_dq0_o  = addr_q[5'd23 - bit_cnt[4:0]];
                io_qspi_dq0_oe = 1'b1;
                if (bit_end && last_bit) state_n = (blen_q != '0) ? DATA : CS_HOLD;
            end
            DATA: begin
                // Write bytes wrap through the 32-bit word every four bytes.
                io_qspi_dq0_o  = ~is_read & wdata_q[5'd31 - bit_cnt[4:0]];
                io_qspi_dq0_oe = ~is_read;
                if (bit_end && last_bit) state_n = CS_HOLD;
            end
            CS_HOLD: begin
                if (half_end) state_n = CS_IDLE;
            end
            CS_IDLE: begin
                io_qspi_cs_n = 1'b1;
`ifdef QSPI_CCHAN_BUSY_POLL_EN
                if (csh_done) state_n = poll_pend ? POLL : IDLE;
`else
                if (csh_done) state_n = IDLE;
`endif
            end
`ifdef QSPI_CCHAN_BUSY_POLL_EN
            POLL: begin
                io_qspi_cs_n = 1'b1;
                state_n      = CS_SETUP;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state        <= IDLE;
            hc           <= '0;
            ph           <= 1'b0;
            bit_cnt      <= '0;
            inst_q       <= '0;
            addr_q       <= '0;
            blen_q       <= '0;
            wdata_q      <= '0;
            rx_sr        <= '0;
            has_addr     <= 1'b0;
            is_read      <= 1'b0;
            csh_cnt      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef QSPI_CCHAN_BUSY_POLL_EN
            poll_pend    <= 1'b0;
            in_poll      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            resp_valid_q <= 1'b0;
            if (state inside {CS_SETUP, INST, ADDR, DATA, CS_HOLD})
                hc <= half_end ? '0 : hc + HW'(1);
            else
                hc <= '0;

            case (state)
                IDLE: begin
                    if (io_cchan.req_valid) begin
                        inst_q   <= io_cchan.req_inst;
                        addr_q   <= io_cchan.req_addr;
                        blen_q   <= io_cchan.req_data_burstlen;
                        wdata_q  <= io_cchan.wdata;
                        rx_sr    <= '0;
                        bit_cnt  <= '0;
                        ph       <= 1'b0;
                        has_addr <= (io_cchan.req_inst == INST_SER)   ||
                                    (io_cchan.req_inst == INST_BER32) ||
                                    (io_cchan.req_inst == INST_BER64);
                        is_read  <= (io_cchan.req_inst == INST_RDSR)  ||
                                    (io_cchan.req_inst == INST_RDFR);
`ifdef QSPI_CCHAN_BUSY_POLL_EN
                        poll_pend <= (io_cchan.req_inst == INST_SER)   ||
                                     (io_cchan.req_inst == INST_BER32) ||
                                     (io_cchan.req_inst == INST_BER64) ||
                                     (io_cchan.req_inst == INST_CER)   ||
                                     (io_cchan.req_inst == INST_WRSR);
                        in_poll   <= 1'b0;
`endif
                    end
                end
                INST, ADDR, DATA: begin
                    // MISO is captured on the edge that raises sck.
                    if (half_end) begin
                        if (!ph) begin
                            ph <= 1'b1;
                            if (state == DATA && is_read)
                                rx_sr <= {rx_sr[30:0], io_qspi_dq1_i};
                        end else begin
                            ph      <= 1'b0;
                            bit_cnt <= last_bit ? '0 : bit_cnt + 12'd1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (half_end) begin
`ifdef QSPI_CCHAN_BUSY_POLL_EN
                        if (!withhold) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= is_read ? rx_sr : '0;
                            poll_pend    <= 1'b0;
                            in_poll      <= 1'b0;
                        end
`else
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= is_read ? rx_sr : '0;
`endif
                    end
                end
                CS_IDLE: begin
                    csh_cnt <= csh_done ? '0 : csh_cnt + 8'd1;
                end
`ifdef QSPI_CCHAN_BUSY_POLL_EN
                POLL: begin
                    inst_q   <= INST_RDSR;
                    has_addr <= 1'b0;
                    is_read  <= 1'b1;
                    blen_q   <= 8'd1;
                    rx_sr    <= '0;
                    bit_cnt  <= '0;
                    in_poll  <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
